// File: rtl/unified_mem_arbiter.sv
// Arbiter sharing one variable-latency memory port between instruction fetch
// and data access; one access in flight, with a bounded data-priority streak.
module unified_mem_arbiter #(
  parameter int MAX_DSTREAK = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  im_command,
  input  logic [31:0] im_addr,
  input  logic        im_flush,
  output logic [31:0] im_rdata,
  output logic        im_valid,
  output logic        im_stall,
  input  logic [1:0]  dm_command,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_valid,
  output logic        dm_stall,
  output logic [1:0]  mem_command,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  localparam logic [1:0] BUS_NONE  = 2'b00;
  localparam logic [1:0] BUS_LOAD  = 2'b01;
  localparam logic [1:0] BUS_STORE = 2'b10;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic [1:0]  cmd_q, cmd_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] im_rdata_q, im_rdata_d;
  logic [31:0] dm_rdata_q, dm_rdata_d;
  logic        src_dm_q, src_dm_d;
  logic [3:0]  dstreak_q, dstreak_d;
  logic        flush_q, flush_d;

  logic im_req, dm_req, pick_im;

  assign im_req  = (im_command == BUS_LOAD);
  assign dm_req  = (dm_command == BUS_LOAD) || (dm_command == BUS_STORE);
  // Data normally wins; a full streak hands the port to a waiting fetch.
  assign pick_im = im_req && (!dm_req || (dstreak_q == 4'(MAX_DSTREAK)));

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    im_rdata_d = im_rdata_q;
    dm_rdata_d = dm_rdata_q;
    src_dm_d   = src_dm_q;
    dstreak_d  = dstreak_q;
    flush_d    = flush_q;

    if (im_flush && !src_dm_q && (state_q == ISSUE || state_q == WAIT))
      flush_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (!im_req)
          dstreak_d = '0;
        if (im_req || dm_req) begin
          state_d = ISSUE;
          if (pick_im) begin
            src_dm_d  = 1'b0;
            cmd_d     = BUS_LOAD;
            addr_d    = im_addr;
            wdata_d   = '0;
            dstreak_d = '0;
          end else begin
            src_dm_d = 1'b1;
            cmd_d    = dm_command;
            addr_d   = dm_addr;
            wdata_d  = dm_wdata;
            if (im_req)
              dstreak_d = dstreak_q + 4'd1;
          end
        end
      end
      ISSUE: begin
        if (mem_ack)
          state_d = (cmd_q == BUS_LOAD) ? WAIT : RESP;
      end
      WAIT: begin
        if (mem_rvalid) begin
          state_d = RESP;
          if (src_dm_q) dm_rdata_d = mem_rdata;
          else          im_rdata_d = mem_rdata;
        end
      end
      RESP: begin
        state_d = IDLE;
        flush_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cmd_q      <= BUS_NONE;
      addr_q     <= '0;
      wdata_q    <= '0;
      im_rdata_q <= '0;
      dm_rdata_q <= '0;
      src_dm_q   <= 1'b0;
      dstreak_q  <= '0;
      flush_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      im_rdata_q <= im_rdata_d;
      dm_rdata_q <= dm_rdata_d;
      src_dm_q   <= src_dm_d;
      dstreak_q  <= dstreak_d;
      flush_q    <= flush_d;
    end
  end

  assign mem_command = (state_q == ISSUE) ? cmd_q : BUS_NONE;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign im_rdata    = im_rdata_q;
  assign dm_rdata    = dm_rdata_q;
  assign im_valid    = (state_q == RESP) && !src_dm_q && !flush_q;
  assign dm_valid    = (state_q == RESP) && src_dm_q;
  assign im_stall    = im_req && !im_valid;
  assign dm_stall    = dm_req && !dm_valid;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench for unified_mem_arbiter: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_unified_mem_arbiter;

  localparam int MAXD = 2;
  localparam logic [1:0] NONE = 2'b00, LOAD = 2'b01, STORE = 2'b10;

  logic        clk, rst;
  logic [1:0]  im_command, dm_command, mem_command;
  logic [31:0] im_addr, dm_addr, dm_wdata, im_rdata, dm_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        im_flush, im_valid, im_stall, dm_valid, dm_stall;
  logic        mem_ack, mem_rvalid, busy;

  int cmp = 0;
  int err = 0;
  int cyc = 0;

  // memory responder state
  int          ack_dly = 0, rv_dly = 0, ack_cnt = 0, rv_cnt = 0;
  bit          rv_pend = 0, rand_lat = 0, noise = 0, fix_en = 0;
  bit          ack_seen = 0, rv_seen = 0;
  logic [31:0] fix_val = 0, rv_addr = 0, ack_addr = 0;

  unified_mem_arbiter #(.MAX_DSTREAK(MAXD)) dut (
    .clk(clk), .rst(rst),
    .im_command(im_command), .im_addr(im_addr), .im_flush(im_flush),
    .im_rdata(im_rdata), .im_valid(im_valid), .im_stall(im_stall),
    .dm_command(dm_command), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid), .dm_stall(dm_stall),
    .mem_command(mem_command), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  function automatic logic [31:0] memval(input logic [31:0] a);
    if (fix_en) return fix_val;
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C ^ (a << 3);
  endfunction

  task automatic resp_clear();
    ack_cnt = 0; rv_cnt = 0; rv_pend = 0; mem_ack = 0; mem_rvalid = 0;
  endtask

  // Advance to just after the next rising edge and drive the memory side for
  // the new cycle, based on the command the arbiter now presents.
  task automatic tick();
    @(posedge clk); #1;
    cyc++;
    ack_seen = 0; rv_seen = 0;
    mem_ack = 0; mem_rvalid = 0; mem_rdata = $urandom;
    if (mem_command == LOAD || mem_command == STORE) begin
      if (ack_cnt < ack_dly) ack_cnt++;
      else begin
        mem_ack = 1; ack_cnt = 0; ack_seen = 1; ack_addr = mem_addr;
        if (mem_command == LOAD) begin rv_pend = 1; rv_addr = mem_addr; rv_cnt = 0; end
        if (rand_lat) begin ack_dly = $urandom_range(0, 3); rv_dly = $urandom_range(0, 3); end
      end
    end else if (rv_pend) begin
      if (rv_cnt < rv_dly) rv_cnt++;
      else begin mem_rvalid = 1; mem_rdata = memval(rv_addr); rv_pend = 0; rv_seen = 1; end
    end
    if (noise) begin
      if (!mem_ack && mem_command == NONE && $urandom_range(0, 7) == 0) mem_ack = 1;
      if (!mem_rvalid && !mem_ack && !rv_pend && $urandom_range(0, 7) == 0) mem_rvalid = 1;
    end
  endtask

  task automatic test_reset();
    rst = 1; im_command = LOAD; dm_command = LOAD; im_addr = 32'h44; dm_addr = 32'h88;
    dm_wdata = 0; im_flush = 0; mem_ack = 1; mem_rvalid = 0; mem_rdata = 0;
    repeat (3) @(negedge clk);
    cmp++; if ({busy, im_valid, dm_valid, mem_command} !== 5'b0)
      begin err++; $display("FAIL reset_ctrl: got %b want 00000", {busy, im_valid, dm_valid, mem_command}); end
    cmp++; if ({mem_addr, mem_wdata} !== 64'h0)
      begin err++; $display("FAIL reset_mem: got %h want 0", {mem_addr, mem_wdata}); end
    cmp++; if ({im_rdata, dm_rdata} !== 64'h0)
      begin err++; $display("FAIL reset_rdata: got %h want 0", {im_rdata, dm_rdata}); end
    cmp++; if ({im_stall, dm_stall} !== 2'b11)
      begin err++; $display("FAIL reset_stall: got %b want 11", {im_stall, dm_stall}); end
    im_command = NONE; dm_command = NONE; resp_clear();
    @(negedge clk); rst = 0;
    cmp++; if ({im_stall, dm_stall} !== 2'b00)
      begin err++; $display("FAIL idle_stall: got %b want 00", {im_stall, dm_stall}); end
  endtask

  task automatic test_if_load();
    logic [4:0] e_stall, e_valid, e_mload;
    e_stall = 5'b00111; e_valid = 5'b01000; e_mload = 5'b00010;
    fix_en = 1; fix_val = 32'h0000_0013; ack_dly = 0; rv_dly = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (k == 0) begin im_command = LOAD; im_addr = 32'h100; end
      if (k == 4) im_command = NONE;
      @(negedge clk);
      cmp++; if (im_stall !== e_stall[k])
        begin err++; $display("FAIL if_stall c%0d: got %b want %b", k, im_stall, e_stall[k]); end
      cmp++; if (im_valid !== e_valid[k])
        begin err++; $display("FAIL if_valid c%0d: got %b want %b", k, im_valid, e_valid[k]); end
      cmp++; if ((mem_command == LOAD) !== e_mload[k])
        begin err++; $display("FAIL if_cmd c%0d: got %b", k, mem_command); end
      if (k == 1) begin
        cmp++; if (mem_addr !== 32'h100)
          begin err++; $display("FAIL if_addr: got %h want 00000100", mem_addr); end
      end
      if (k == 3) begin
        cmp++; if (im_rdata !== 32'h13)
          begin err++; $display("FAIL if_rdata: got %h want 00000013", im_rdata); end
      end
    end
    fix_en = 0;
  endtask

  task automatic test_simultaneous();
    int dv_c, iv_c, dvn, ivn;
    dv_c = -1; iv_c = -1; dvn = 0; ivn = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (k == 0) begin
        im_command = LOAD;  im_addr = 32'h200;
        dm_command = STORE; dm_addr = 32'h400; dm_wdata = 32'hDEAD_BEEF;
      end
      if (dv_c >= 0 && k == dv_c + 1) dm_command = NONE;
      if (iv_c >= 0 && k == iv_c + 1) im_command = NONE;
      @(negedge clk);
      if (k == 1) begin
        cmp++; if ({mem_command, mem_addr, mem_wdata} !== {STORE, 32'h400, 32'hDEAD_BEEF})
          begin err++; $display("FAIL sim_store_issue: got %b %h %h", mem_command, mem_addr, mem_wdata); end
      end
      if (k == 4) begin
        cmp++; if ({mem_command, mem_addr} !== {LOAD, 32'h200})
          begin err++; $display("FAIL sim_load_issue: got %b %h want 01 00000200", mem_command, mem_addr); end
      end
      if (dm_valid) begin dvn++; if (dv_c < 0) dv_c = k; end
      if (im_valid) begin ivn++; if (iv_c < 0) iv_c = k; end
    end
    cmp++; if (dv_c != 2 || dvn != 1)
      begin err++; $display("FAIL sim_dm_valid: got cycle %0d x%0d want cycle 2 x1", dv_c, dvn); end
    cmp++; if (iv_c != 6 || ivn != 1)
      begin err++; $display("FAIL sim_im_valid: got cycle %0d x%0d want cycle 6 x1", iv_c, ivn); end
    cmp++; if (im_rdata !== memval(32'h200))
      begin err++; $display("FAIL sim_im_rdata: got %h want %h", im_rdata, memval(32'h200)); end
  endtask

  task automatic test_fairness();
    logic [7:0] order, want;
    int ng, k;
    order = 0; want = 8'b0001_1011; ng = 0; k = 0;
    while (ng < 6 && k < 80) begin
      tick();
      if (ack_seen) begin order[ng] = ack_addr[31]; ng++; end
      if (k == 0) begin
        im_command = LOAD; im_addr = 32'h0000_0A00;
        dm_command = LOAD; dm_addr = 32'h8000_0000;
      end
      @(negedge clk);
      if (dm_valid) dm_addr = dm_addr + 32'd4;
      k++;
    end
    cmp++; if (ng < 6)
      begin err++; $display("FAIL fair_timeout: got %0d grants want 6", ng); end
    for (int g = 0; g < 6; g++) begin
      if (g < ng) begin
        cmp++; if (order[g] !== want[g])
          begin err++; $display("FAIL fair_grant%0d: got %s want %s", g, order[g] ? "D" : "I", want[g] ? "D" : "I"); end
      end
    end
    im_command = NONE; dm_command = NONE;
    k = 0;
    while (busy && k < 40) begin tick(); @(negedge clk); k++; end
    cmp++; if (busy !== 1'b0)
      begin err++; $display("FAIL fair_drain: busy got %b want 0", busy); end
  endtask

  task automatic test_flush();
    for (int k = 0; k < 9; k++) begin
      tick();
      im_flush = 0;
      if (k == 0) begin im_command = LOAD; im_addr = 32'h100; end
      if (k == 2) begin im_flush = 1; im_addr = 32'h300; end
      if (k == 8) im_command = NONE;
      @(negedge clk);
      if (k < 7) begin
        cmp++; if (im_valid !== 1'b0)
          begin err++; $display("FAIL flush_valid c%0d: got %b want 0", k, im_valid); end
      end
      if (k == 3) begin
        cmp++; if (im_stall !== 1'b1)
          begin err++; $display("FAIL flush_stall: got %b want 1", im_stall); end
      end
      if (k == 4) begin
        cmp++; if (busy !== 1'b0)
          begin err++; $display("FAIL flush_idle: busy got %b want 0", busy); end
      end
      if (k == 5) begin
        cmp++; if ({mem_command, mem_addr} !== {LOAD, 32'h300})
          begin err++; $display("FAIL flush_reissue: got %b %h want 01 00000300", mem_command, mem_addr); end
      end
      if (k == 7) begin
        cmp++; if ({im_valid, im_rdata} !== {1'b1, memval(32'h300)})
          begin err++; $display("FAIL flush_new: got %b %h want 1 %h", im_valid, im_rdata, memval(32'h300)); end
      end
    end
  endtask

  task automatic test_slow_mem();
    int dvn;
    logic [31:0] a;
    dvn = 0; a = 32'h8000_0040; ack_dly = 3; rv_dly = 4;
    for (int k = 0; k < 13; k++) begin
      tick();
      if (k == 0) begin dm_command = LOAD; dm_addr = a; end
      if (k == 2) begin mem_rvalid = 1; mem_rdata = 32'hBAD0_BAD0; end
      if (k == 11) dm_command = NONE;
      @(negedge clk);
      if (k >= 1 && k <= 4) begin
        cmp++; if ({mem_command, mem_addr} !== {LOAD, a})
          begin err++; $display("FAIL slow_hold c%0d: got %b %h", k, mem_command, mem_addr); end
      end
      if (k >= 1 && k <= 10) begin
        cmp++; if (busy !== 1'b1)
          begin err++; $display("FAIL slow_busy c%0d: got %b want 1", k, busy); end
      end
      if (dm_valid) dvn++;
      if (k == 10) begin
        cmp++; if ({dm_valid, dm_rdata} !== {1'b1, memval(a)})
          begin err++; $display("FAIL slow_resp: got %b %h want 1 %h", dm_valid, dm_rdata, memval(a)); end
      end
    end
    cmp++; if (dvn != 1)
      begin err++; $display("FAIL slow_pulses: got %0d want 1", dvn); end
    ack_dly = 0; rv_dly = 0;
  endtask

  task automatic test_async_reset();
    logic [31:0] a2;
    a2 = 32'h8000_0100; rv_dly = 3;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k == 0) begin dm_command = LOAD; dm_addr = 32'h8000_0080; end
    end
    #2 rst = 1;
    #1;
    cmp++; if ({busy, im_valid, dm_valid, mem_command} !== 5'b0)
      begin err++; $display("FAIL arst_ctrl: got %b want 00000", {busy, im_valid, dm_valid, mem_command}); end
    cmp++; if ({mem_addr, mem_wdata} !== 64'h0)
      begin err++; $display("FAIL arst_mem: got %h want 0", {mem_addr, mem_wdata}); end
    cmp++; if ({im_rdata, dm_rdata} !== 64'h0)
      begin err++; $display("FAIL arst_rdata: got %h want 0", {im_rdata, dm_rdata}); end
    @(posedge clk); #1;
    dm_command = NONE; resp_clear(); rv_dly = 0;
    @(negedge clk); rst = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (k == 0) begin dm_command = LOAD; dm_addr = a2; end
      if (k == 4) dm_command = NONE;
      @(negedge clk);
      cmp++; if (dm_valid !== (k == 3))
        begin err++; $display("FAIL arst_fresh c%0d: dm_valid got %b", k, dm_valid); end
      if (k == 3) begin
        cmp++; if (dm_rdata !== memval(a2))
          begin err++; $display("FAIL arst_rdata_new: got %h want %h", dm_rdata, memval(a2)); end
      end
    end
  endtask

  // Reference model works on transactions: a grant is decided in a free cycle,
  // the access completes one cycle after the memory's final handshake, and the
  // port is free again the cycle after that.
  task automatic test_random();
    bit m_active, m_acked, m_src, m_flushed, i_out, d_out, e_iv, e_dv, iq, dq, iv_prev, dv_prev, quiet;
    int m_resp, m_streak;
    logic [1:0] m_cmd, c;
    logic [31:0] m_addr;
    m_active = 0; m_acked = 0; m_src = 0; m_flushed = 0; i_out = 0; d_out = 0;
    iv_prev = 0; dv_prev = 0; m_resp = -1; m_streak = 0; m_cmd = NONE; m_addr = 0;
    rand_lat = 1; noise = 1;
    for (int n = 0; n < 1500; n++) begin
      tick();
      quiet = (n >= 1440);
      if (iv_prev) i_out = 0;
      if (dv_prev) d_out = 0;
      im_flush = 0;
      if (!i_out) begin
        if (!quiet && $urandom_range(0, 1) == 1) begin
          im_command = LOAD; im_addr = $urandom & 32'h7FFF_FFFC; i_out = 1;
        end else begin
          c = 2'($urandom_range(0, 2));
          im_command = (c == 2'b01) ? 2'b11 : c;
        end
      end
      if (!d_out) begin
        if (!quiet && $urandom_range(0, 1) == 1) begin
          dm_command = ($urandom_range(0, 1) == 1) ? LOAD : STORE;
          dm_addr = ($urandom & 32'hFFFF_FFFC) | 32'h8000_0000; dm_wdata = $urandom; d_out = 1;
        end else dm_command = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00;
      end
      if (!quiet && $urandom_range(0, 15) == 0 && !(m_active && m_resp == cyc)) begin
        im_flush = 1;
        if (i_out) im_addr = $urandom & 32'h7FFF_FFFC;
      end
      iq = (im_command == LOAD);
      dq = (dm_command == LOAD) || (dm_command == STORE);
      if (im_flush && m_active && !m_src && m_resp != cyc) m_flushed = 1;
      @(negedge clk);
      e_iv = m_active && !m_src && (m_resp == cyc) && !m_flushed;
      e_dv = m_active && m_src && (m_resp == cyc);
      cmp++; if ({im_valid, dm_valid} !== {e_iv, e_dv})
        begin err++; $display("FAIL rnd_valid c%0d: got %b%b want %b%b", cyc, im_valid, dm_valid, e_iv, e_dv); end
      cmp++; if (busy !== m_active)
        begin err++; $display("FAIL rnd_busy c%0d: got %b want %b", cyc, busy, m_active); end
      cmp++; if ({im_stall, dm_stall} !== {iq && !e_iv, dq && !e_dv})
        begin err++; $display("FAIL rnd_stall c%0d: got %b%b want %b%b", cyc, im_stall, dm_stall, iq && !e_iv, dq && !e_dv); end
      cmp++; if (mem_command !== ((m_active && !m_acked) ? m_cmd : NONE))
        begin err++; $display("FAIL rnd_cmd c%0d: got %b", cyc, mem_command); end
      if (m_active && !m_acked) begin
        cmp++; if (mem_addr !== m_addr)
          begin err++; $display("FAIL rnd_addr c%0d: got %h want %h", cyc, mem_addr, m_addr); end
      end
      if (e_iv) begin
        cmp++; if (im_rdata !== memval(m_addr))
          begin err++; $display("FAIL rnd_im_rdata c%0d: got %h want %h", cyc, im_rdata, memval(m_addr)); end
      end
      if (e_dv && m_cmd == LOAD) begin
        cmp++; if (dm_rdata !== memval(m_addr))
          begin err++; $display("FAIL rnd_dm_rdata c%0d: got %h want %h", cyc, dm_rdata, memval(m_addr)); end
      end
      iv_prev = im_valid; dv_prev = dm_valid;
      if (m_active) begin
        if (m_resp == cyc) m_active = 0;
        else if (!m_acked) begin
          if (ack_seen) begin m_acked = 1; if (m_cmd == STORE) m_resp = cyc + 1; end
        end else if (m_resp < 0 && rv_seen) m_resp = cyc + 1;
      end else begin
        if (!iq) m_streak = 0;
        if (iq || dq) begin
          m_src = dq && !(iq && m_streak == MAXD);
          if (m_src) begin
            m_cmd = dm_command; m_addr = dm_addr;
            if (iq) m_streak++;
          end else begin
            m_cmd = LOAD; m_addr = im_addr; m_streak = 0;
          end
          m_active = 1; m_acked = 0; m_resp = -1; m_flushed = 0;
        end
      end
    end
    rand_lat = 0; noise = 0; ack_dly = 0; rv_dly = 0;
    im_command = NONE; dm_command = NONE; im_flush = 0;
  endtask

  initial begin
    test_reset();
    test_if_load();
    test_simultaneous();
    test_fairness();
    test_flush();
    test_slow_mem();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end

endmodule
